hmc_tx_flit_packer: RTL
=======================

HMC_TX_FLIT_PACKER -- requirements
Module: hmc_tx_flit_packer

Interface
REQ-001 Parameter FPW, default 4, flits per word; legal values 2, 4, 6, 8.
REQ-002 Parameter LOG_FPW, default 2, ceil(log2(FPW)).
REQ-003 Parameter DWIDTH, default FPW*128, output data width; do not override.
REQ-004 Parameter NUM_DATA_BYTES, default FPW*16, TUSER width; do not override.
REQ-005 Port clk_hmc, input, 1, sole clock; all logic on its rising edge.
REQ-006 Port res_hmc, input, 1, reset, synchronous, active-high.
REQ-007 Port in_valid, input, 1, flit offered.
REQ-008 Port in_ready, output, 1, flit accepted when in_valid && in_ready.
REQ-009 Port in_flit, input, 128, one HMC flit.
REQ-010 Port in_hdr, input, 1, flit is a packet header.
REQ-011 Port in_tail, input, 1, flit is a packet tail; hdr and tail may both be set.
REQ-012 Port flush, input, 1, force emission of a partial word.
REQ-013 Port s_axis_tx_TVALID, output, 1, word valid toward the controller TX.
REQ-014 Port s_axis_tx_TREADY, input, 1, controller accepts the word.
REQ-015 Port s_axis_tx_TDATA, output, DWIDTH, flit i in bits [128*i+127:128*i].
REQ-016 Port s_axis_tx_TUSER, output, NUM_DATA_BYTES, [FPW-1:0] valid, [2FPW-1:FPW] hdr, [3FPW-1:2FPW] tail per flit, upper bits 0.
REQ-017 Port pkt_cnt, output, 32, number of tail flits emitted on s_axis_tx.

Function
REQ-018 Accepted flits shall fill the assembly register in slot order 0..FPW-1; write pointer ptr is LOG_FPW+1 bits, range 0..FPW.
REQ-019 Output register is free when TVALID=0 or TVALID&&TREADY in the same cycle.
REQ-020 A flit accepted into slot FPW-1 while the output register is free shall load the completed word into the output register in that cycle; ptr returns to 0 (zero bubble, full throughput).
REQ-021 If slot FPW-1 is filled while the output register is not free, ptr shall become FPW and in_ready=0 until the transfer; the transfer occurs on the first free cycle, ptr to 0.
REQ-022 in_ready = (ptr != FPW).
REQ-023 Partial emission: when 0<ptr<FPW and (flush=1, or the last accepted flit had tail=1 and in_valid=0 this cycle) and the output register is free, the partial word shall transfer; ptr returns to 0.
REQ-024 Slots not written in an emitted word shall have data 0 and valid/hdr/tail bits 0.
REQ-025 While TVALID=1 and TREADY=0, TVALID, TDATA and TUSER shall remain unchanged.
REQ-026 TVALID shall not depend combinationally on TREADY; latency in_valid to TVALID is 1 cycle minimum.
REQ-027 A flit arriving while a partial transfer condition holds shall not be merged into the departing word; it goes to slot 0 of the next word.
REQ-028 pkt_cnt shall increment by the number of set tail bits on each TVALID&&TREADY cycle, wrapping modulo 2^32.
REQ-029 flush with ptr=0 shall have no effect.

Reset
REQ-030 With res_hmc=1 at a clock edge: TVALID=0, TDATA=0, TUSER=0, ptr=0, pkt_cnt=0, last-tail flag=0; in_ready=1 after the reset cycle.
REQ-031 Reset mid-operation shall discard assembled and pending flits without emitting them.

Structure
REQ-032 TUSER field offsets, the flit width (128) and a per-flit struct {data, hdr, tail} shall reside in the shared package hmc_tx_pkg.
REQ-033 Implementation shall be a single module with no sub-modules; the output register is a one-entry skid stage inside it.

Verification (FPW=4)
REQ-034 Eight back-to-back flits, TREADY=1 -> two words with TUSER valid=4'hF each, no in_ready deassertion.
REQ-035 Three-flit packet (hdr on flit 0, tail on flit 2), then idle -> one word, valid=4'b0111, hdr=4'b0001, tail=4'b0100, slot 3 data 0; pkt_cnt=1.
REQ-036 TREADY=0 for 10 cycles with a word pending -> TVALID, TDATA, TUSER stable all 10 cycles; in_ready=0 once ptr=4.
REQ-037 One flit then flush=1 -> word with valid=4'b0001; flush with ptr=0 -> no word.
REQ-038 res_hmc asserted with ptr=2 and a stalled word -> TVALID=0 next cycle, pkt_cnt=0, no stale flit in the following word.
REQ-039 All runs bound to the AXI hold assertions on s_axis_tx_*; zero failures required.

Source files
------------

// File: rtl/hmc_tx_pkg.sv
// Shared definitions for the HMC TX flit packer: flit width,
// per-flit bundle and TUSER field placement.
package hmc_tx_pkg;

    localparam int FLIT_W = 128;

    // TUSER holds three FPW-wide fields; offset = selector * FPW.
    localparam int TUSER_VALID_SEL = 0;
    localparam int TUSER_HDR_SEL   = 1;
    localparam int TUSER_TAIL_SEL  = 2;

    typedef struct packed {
        logic [FLIT_W-1:0] data;
        logic              hdr;
        logic              tail;
    } flit_t;

    function automatic int tuser_ofs(input int sel, input int fpw);
        return sel * fpw;
    endfunction

endpackage

// File: rtl/hmc_tx_flit_packer.sv
// Packs single 128-bit HMC flits into FPW-flit words for the controller TX
// AXI stream, with a one-entry output skid register and flush/tail-driven
// partial emission.
// Ports: clk_hmc/res_hmc; in_valid/in_ready/in_flit/in_hdr/in_tail/flush
// flit input; s_axis_tx_* word output; pkt_cnt counts emitted tails.
module hmc_tx_flit_packer
    import hmc_tx_pkg::*;
#(
    parameter int FPW            = 4,
    parameter int LOG_FPW        = 2,
    parameter int DWIDTH         = FPW * 128,
    parameter int NUM_DATA_BYTES = FPW * 16
) (
    input  logic                      clk_hmc,
    input  logic                      res_hmc,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FLIT_W-1:0]         in_flit,
    input  logic                      in_hdr,
    input  logic                      in_tail,
    input  logic                      flush,
    output logic                      s_axis_tx_TVALID,
    input  logic                      s_axis_tx_TREADY,
    output logic [DWIDTH-1:0]         s_axis_tx_TDATA,
    output logic [NUM_DATA_BYTES-1:0] s_axis_tx_TUSER,
    output logic [31:0]               pkt_cnt
);

    localparam int VOFS = tuser_ofs(TUSER_VALID_SEL, FPW);
    localparam int HOFS = tuser_ofs(TUSER_HDR_SEL, FPW);
    localparam int TOFS = tuser_ofs(TUSER_TAIL_SEL, FPW);

    localparam logic [LOG_FPW:0] PTR_FULL = (LOG_FPW+1)'(FPW);
    localparam logic [LOG_FPW:0] PTR_LAST = (LOG_FPW+1)'(FPW - 1);

    flit_t                     asm_q [FPW];
    flit_t                     asm_d [FPW];
    flit_t                     src   [FPW];
    flit_t                     in_f;
    logic [LOG_FPW:0]          ptr_q, ptr_d;
    logic [LOG_FPW:0]          cnt;
    logic                      last_tail_q, last_tail_d;
    logic                      tvalid_q, tvalid_d;
    logic [DWIDTH-1:0]         tdata_q, tdata_d, tdata_w;
    logic [NUM_DATA_BYTES-1:0] tuser_q, tuser_d, tuser_w;
    logic [31:0]               pkt_cnt_q, pkt_cnt_d;
    logic [31:0]               tail_pop;
    logic                      out_free;
    logic                      accept;
    logic                      part_go;
    logic                      emit;

    assign in_f     = '{data: in_flit, hdr: in_hdr, tail: in_tail};
    assign out_free = !tvalid_q || s_axis_tx_TREADY;
    assign in_ready = (ptr_q != PTR_FULL);
    assign accept   = in_valid && in_ready;

    // Partial word leaves on flush, or once a tail was the last flit in
    // and the input has gone idle.
    assign part_go = (ptr_q != '0) && (ptr_q != PTR_FULL) && out_free &&
                     (flush || (last_tail_q && !in_valid));

    assign last_tail_d = accept ? in_tail : last_tail_q;

    always_comb begin
        asm_d = asm_q;
        src   = asm_q;
        ptr_d = ptr_q;
        cnt   = ptr_q;
        emit  = 1'b0;
        if (ptr_q == PTR_FULL) begin
            if (out_free) begin
                emit  = 1'b1;
                ptr_d = '0;
            end
        end else if (part_go) begin
            // A concurrent flit starts the next word, never this one.
            emit = 1'b1;
            if (accept) begin
                asm_d[0] = in_f;
                ptr_d    = (LOG_FPW+1)'(1);
            end else begin
                ptr_d = '0;
            end
        end else if (accept) begin
            for (int i = 0; i < FPW; i++) begin
                if (ptr_q == (LOG_FPW+1)'(i)) asm_d[i] = in_f;
            end
            if (ptr_q == PTR_LAST) begin
                if (out_free) begin
                    emit  = 1'b1;
                    src   = asm_d;
                    cnt   = PTR_FULL;
                    ptr_d = '0;
                end else begin
                    ptr_d = PTR_FULL;
                end
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // Slots at or beyond the fill count are forced to zero.
    always_comb begin
        tdata_w = '0;
        tuser_w = '0;
        for (int i = 0; i < FPW; i++) begin
            if ((LOG_FPW+1)'(i) < cnt) begin
                tdata_w[FLIT_W*i +: FLIT_W] = src[i].data;
                tuser_w[VOFS+i]             = 1'b1;
                tuser_w[HOFS+i]             = src[i].hdr;
                tuser_w[TOFS+i]             = src[i].tail;
            end
        end
    end

    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        if (emit) begin
            tvalid_d = 1'b1;
            tdata_d  = tdata_w;
            tuser_d  = tuser_w;
        end else if (tvalid_q && s_axis_tx_TREADY) begin
            tvalid_d = 1'b0;
        end
    end

    always_comb begin
        tail_pop = '0;
        for (int i = 0; i < FPW; i++) begin
            tail_pop = tail_pop + 32'(tuser_q[TOFS+i]);
        end
    end

    assign pkt_cnt_d = (tvalid_q && s_axis_tx_TREADY) ?
                       pkt_cnt_q + tail_pop : pkt_cnt_q;

    always_ff @(posedge clk_hmc) begin
        if (res_hmc) begin
            ptr_q       <= '0;
            last_tail_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tuser_q     <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            last_tail_q <= last_tail_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    // Assembly slots are masked by the fill count, so no reset needed.
    always_ff @(posedge clk_hmc) begin
        asm_q <= asm_d;
    end

    assign s_axis_tx_TVALID = tvalid_q;
    assign s_axis_tx_TDATA  = tdata_q;
    assign s_axis_tx_TUSER  = tuser_q;
    assign pkt_cnt          = pkt_cnt_q;

endmodule
